// File: rtl/branch_unit.sv
// ---------------------------------------------------------------------------
// branch_unit
//
// Purpose:
//   Resolves the branch decision for the RV32I execute stage. It combines the
//   two source operands with the major opcode bits [6:2] and funct3, and
//   produces one registered "taken" flag that feeds the PC-select / redirect
//   logic. JAL and JALR always report taken. BRANCH-class instructions compare
//   rs1 against rs2 as selected by funct3. Every other opcode, and the
//   reserved funct3 encodings 010/011, report not taken.
//
// Ports:
//   clk_in            input   1     system clock, rising-edge active
//   rst_n_in          input   1     synchronous reset, active-low
//   rs1_in            input   XLEN  source operand 1 (rs1 value)
//   rs2_in            input   XLEN  source operand 2 (rs2 value)
//   opcode_6_to_2_in  input   5     instruction bits [6:2]
//   funct3_in         input   3     instruction bits [14:12]
//   branch_taken_out  output  1     registered branch/jump taken flag
// ---------------------------------------------------------------------------
module branch_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [4:0]      opcode_6_to_2_in,
  input  logic [2:0]      funct3_in,
  output logic            branch_taken_out
);

  // Major opcode encodings (instruction bits [6:2]) that this unit decodes.
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  // funct3 encodings of the BRANCH opcode.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  logic [XLEN:0] w_diff;
  logic          w_eq;
  logic          w_ltUnsigned;
  logic          w_ltSigned;
  logic          w_signsDiffer;
  logic          w_taken;
  logic          r_taken;

  // One shared subtractor serves both magnitude compares. The operands are
  // zero-extended by one bit, so the top bit of the difference is the borrow,
  // which is set exactly when rs1 < rs2 as unsigned numbers.
  // For the signed compare: if the sign bits differ, rs1 is less exactly when
  // rs1 is the negative one; if the signs match, two's-complement ordering is
  // the same as unsigned ordering, so the borrow answers it too.
  always_comb begin
    w_diff        = {1'b0, rs1_in} - {1'b0, rs2_in};
    w_eq          = (rs1_in == rs2_in);
    w_ltUnsigned  = w_diff[XLEN];
    w_signsDiffer = rs1_in[XLEN-1] ^ rs2_in[XLEN-1];
    w_ltSigned    = w_signsDiffer ? rs1_in[XLEN-1] : w_ltUnsigned;
  end

  // Decision: jumps are unconditionally taken, branches are steered by
  // funct3, and everything else (including reserved funct3 values) is
  // not taken.
  always_comb begin
    w_taken = 1'b0;
    unique case (opcode_6_to_2_in)
      OP_JAL,
      OP_JALR: begin
        w_taken = 1'b1;
      end
      OP_BRANCH: begin
        unique case (funct3_in)
          F3_BEQ:  w_taken = w_eq;
          F3_BNE:  w_taken = ~w_eq;
          F3_BLT:  w_taken = w_ltSigned;
          F3_BGE:  w_taken = ~w_ltSigned;
          F3_BLTU: w_taken = w_ltUnsigned;
          F3_BGEU: w_taken = ~w_ltUnsigned;
          default: w_taken = 1'b0;
        endcase
      end
      default: begin
        w_taken = 1'b0;
      end
    endcase
  end

  // Output register: reset wins over the decision, so an asserted reset
  // clears the flag at the next edge even while a jump is presented.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_taken <= 1'b0;
    end else begin
      r_taken <= w_taken;
    end
  end

  assign branch_taken_out = r_taken;

endmodule

// File: tb/tb_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_unit
//
// Purpose:
//   Directed test of branch_unit. Each vector carries a hand-computed
//   expected flag, which is queued when the vector is driven; an independent
//   monitor pops the queue one edge later and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_branch_unit;

  typedef struct {
    string name;
    logic  expTaken;
  } expect_t;

  logic        clk;
  logic        rstN;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic        taken;

  expect_t scoreboard[$];
  int      checkCount;
  int      failCount;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  branch_unit #(.XLEN(32)) dut (
    .clk_in           (clk),
    .rst_n_in         (rstN),
    .rs1_in           (rs1),
    .rs2_in           (rs2),
    .opcode_6_to_2_in (opcode),
    .funct3_in        (funct3),
    .branch_taken_out (taken)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one DUT sample with its queued expectation.
  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Drives one vector away from the active edge and queues the flag the DUT
  // must present after the following rising edge.
  task automatic applyStimulus(input string name, input logic rstVal,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] op, input logic [2:0] f3,
                               input logic expTaken);
    expect_t e;
    @(negedge clk);
    rstN   = rstVal;
    rs1    = a;
    rs2    = b;
    opcode = op;
    funct3 = f3;
    e.name     = name;
    e.expTaken = expTaken;
    scoreboard.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: the output is registered, so every rising edge presents a new
  // result; sample it 1 ns later and pair it with the oldest expectation.
  always begin
    expect_t e;
    @(posedge clk);
    #1;
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkOutput(e.name, taken, e.expTaken);
    end
  end

  initial begin
    int drainCycles;
    checkCount = 0;
    failCount  = 0;
    rstN   = 1'b0;
    rs1    = 32'h0;
    rs2    = 32'h0;
    opcode = 5'b0;
    funct3 = 3'b0;

    // Reset held for two edges with JAL presented, then released.
    applyStimulus("reset_edge1", 1'b0, 32'h0, 32'h0, OP_JAL, 3'b000, 1'b0);
    applyStimulus("reset_edge2", 1'b0, 32'h0, 32'h0, OP_JAL, 3'b000, 1'b0);
    applyStimulus("reset_release_jal", 1'b1, 32'h0, 32'h0, OP_JAL, 3'b000, 1'b1);

    // Basic sequence on distinct operands.
    applyStimulus("beq_1_2",  1'b1, 32'h1, 32'h2, OP_BRANCH, 3'b000, 1'b0);
    applyStimulus("jal_1_2",  1'b1, 32'h1, 32'h2, OP_JAL,    3'b000, 1'b1);
    applyStimulus("jalr_1_2", 1'b1, 32'h1, 32'h2, OP_JALR,   3'b000, 1'b1);
    applyStimulus("bgeu_1_2", 1'b1, 32'h1, 32'h2, OP_BRANCH, 3'b111, 1'b0);
    applyStimulus("bltu_1_2", 1'b1, 32'h1, 32'h2, OP_BRANCH, 3'b110, 1'b1);
    applyStimulus("bne_1_2",  1'b1, 32'h1, 32'h2, OP_BRANCH, 3'b001, 1'b1);

    // Equal operands.
    applyStimulus("eq_beq",  1'b1, 32'h12345678, 32'h12345678, OP_BRANCH, 3'b000, 1'b1);
    applyStimulus("eq_bne",  1'b1, 32'h12345678, 32'h12345678, OP_BRANCH, 3'b001, 1'b0);
    applyStimulus("eq_blt",  1'b1, 32'h12345678, 32'h12345678, OP_BRANCH, 3'b100, 1'b0);
    applyStimulus("eq_bge",  1'b1, 32'h12345678, 32'h12345678, OP_BRANCH, 3'b101, 1'b1);
    applyStimulus("eq_bltu", 1'b1, 32'h12345678, 32'h12345678, OP_BRANCH, 3'b110, 1'b0);
    applyStimulus("eq_bgeu", 1'b1, 32'h12345678, 32'h12345678, OP_BRANCH, 3'b111, 1'b1);

    // Sign boundary: 0x80000000 is the most negative signed value but a
    // large unsigned one.
    applyStimulus("sign_blt",  1'b1, 32'h80000000, 32'h7FFFFFFF, OP_BRANCH, 3'b100, 1'b1);
    applyStimulus("sign_bge",  1'b1, 32'h80000000, 32'h7FFFFFFF, OP_BRANCH, 3'b101, 1'b0);
    applyStimulus("sign_bltu", 1'b1, 32'h80000000, 32'h7FFFFFFF, OP_BRANCH, 3'b110, 1'b0);
    applyStimulus("sign_bgeu", 1'b1, 32'h80000000, 32'h7FFFFFFF, OP_BRANCH, 3'b111, 1'b1);
    // Reverse order and same-sign negatives.
    applyStimulus("sign_rev_blt", 1'b1, 32'h7FFFFFFF, 32'h80000000, OP_BRANCH, 3'b100, 1'b0);
    applyStimulus("neg_blt",      1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, OP_BRANCH, 3'b100, 1'b1);
    applyStimulus("neg_bgeu",     1'b1, 32'hFFFFFFFF, 32'h00000000, OP_BRANCH, 3'b111, 1'b1);

    // Reserved funct3 and non-branch opcodes (operands chosen so BEQ/BGE
    // would have been taken).
    applyStimulus("rsvd_f3_010", 1'b1, 32'h5, 32'h5, OP_BRANCH, 3'b010, 1'b0);
    applyStimulus("rsvd_f3_011", 1'b1, 32'h5, 32'h5, OP_BRANCH, 3'b011, 1'b0);
    applyStimulus("op_01100",    1'b1, 32'h5, 32'h5, 5'b01100, 3'b000, 1'b0);
    applyStimulus("op_00100",    1'b1, 32'h9, 32'h3, 5'b00100, 3'b101, 1'b0);
    applyStimulus("op_00000",    1'b1, 32'h9, 32'h3, 5'b00000, 3'b111, 1'b0);
    applyStimulus("op_11010",    1'b1, 32'h9, 32'h3, 5'b11010, 3'b111, 1'b0);

    // Mid-run reset while JAL is held.
    applyStimulus("midrun_jal",     1'b1, 32'h0, 32'h0, OP_JAL, 3'b000, 1'b1);
    applyStimulus("midrun_reset",   1'b0, 32'h0, 32'h0, OP_JAL, 3'b000, 1'b0);
    applyStimulus("midrun_release", 1'b1, 32'h0, 32'h0, OP_JAL, 3'b000, 1'b1);

    // Let the monitor drain the queue, bounded in cycles.
    drainCycles = 0;
    while (scoreboard.size() > 0 && drainCycles < 10) begin
      @(negedge clk);
      drainCycles++;
    end
    checkCount++;
    if (scoreboard.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", scoreboard.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
